// File: rtl/wt64_mult.sv
// Unsigned WIDTH x WIDTH -> 2*WIDTH multiplier: registered operands, Wallace-tree
// carry-save reduction of AND partial products, final carry-propagate add, registered product.
module wt64_mult #(
    parameter int unsigned WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   p
);

    localparam int unsigned PW = 2 * WIDTH;

    // Row count after a number of reduction layers: each full group of three rows
    // becomes two, a leftover pair is half-added into two, a single row passes through.
    function automatic int unsigned rows_after(input int unsigned layers);
        int unsigned n;
        n = WIDTH;
        for (int unsigned i = 0; i < layers; i++) begin
            n = 2 * (n / 3) + (n % 3);
        end
        return n;
    endfunction

    function automatic int unsigned num_layers();
        int unsigned n;
        int unsigned l;
        n = WIDTH;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + (n % 3);
            l++;
        end
        return l;
    endfunction

    localparam int unsigned NumLayers = num_layers();

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_v;
    logic [PW-1:0]    r_p;
    logic             r_ov;

    logic [PW-1:0]    w_pp [WIDTH];
    logic [PW-1:0]    w_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_v <= 1'b0;
        end else begin
            r_a <= a;
            r_b <= b;
            r_v <= in_valid;
        end
    end

    for (genvar j = 0; j < WIDTH; j++) begin : g_pp
        assign w_pp[j] = {{WIDTH{1'b0}}, r_a & {WIDTH{r_b[j]}}} << j;
    end

    for (genvar l = 0; l < NumLayers; l++) begin : g_layer
        localparam int unsigned NIn  = rows_after(l);
        localparam int unsigned NOut = rows_after(l + 1);
        localparam int unsigned NGrp = NIn / 3;
        localparam int unsigned NRem = NIn % 3;

        logic [PW-1:0] w_in  [NIn];
        logic [PW-1:0] w_out [NOut];

        for (genvar r = 0; r < NIn; r++) begin : g_in
            if (l == 0) begin : g_first
                assign w_in[r] = w_pp[r];
            end else begin : g_next
                assign w_in[r] = g_layer[l-1].w_out[r];
            end
        end

        for (genvar g = 0; g < NGrp; g++) begin : g_fa
            assign w_out[2*g]   = w_in[3*g] ^ w_in[3*g+1] ^ w_in[3*g+2];
            assign w_out[2*g+1] = ((w_in[3*g] & w_in[3*g+1]) |
                                   (w_in[3*g] & w_in[3*g+2]) |
                                   (w_in[3*g+1] & w_in[3*g+2])) << 1;
        end

        if (NRem == 2) begin : g_ha
            assign w_out[2*NGrp]   = w_in[3*NGrp] ^ w_in[3*NGrp+1];
            assign w_out[2*NGrp+1] = (w_in[3*NGrp] & w_in[3*NGrp+1]) << 1;
        end else if (NRem == 1) begin : g_pass
            assign w_out[2*NGrp] = w_in[3*NGrp];
        end
    end

    // Carry out of the top bit is dropped; a WIDTH x WIDTH product always fits in PW bits.
    assign w_sum = g_layer[NumLayers-1].w_out[0] + g_layer[NumLayers-1].w_out[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p  <= '0;
            r_ov <= 1'b0;
        end else begin
            r_p  <= w_sum;
            r_ov <= r_v;
        end
    end

    assign p         = r_p;
    assign out_valid = r_ov;

endmodule

// File: tb/tb_wt64_mult.sv
// Self-checking bench for wt64_mult: directed corners, replicated-pattern random
// vectors, valid-pattern pipelining and asynchronous reset, against a plain a*b model.
module tb_wt64_mult;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [63:0]  a = '0;
    logic [63:0]  b = '0;
    logic         out_valid;
    logic [127:0] p;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [127:0] p;
        logic         v;
        string        tag;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    wt64_mult #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .p         (p)
    );

    function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y);
        logic [127:0] xe;
        logic [127:0] ye;
        xe = {64'b0, x};
        ye = {64'b0, y};
        return xe * ye;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pipeline is empty after reset: the next visible output is the cleared state.
    task automatic flush_model();
        exp_t e;
        q.delete();
        e.p = '0;
        e.v = 1'b0;
        e.tag = "after_reset";
        q.push_back(e);
    endtask

    task automatic step(input string tag, input logic [63:0] x, input logic [63:0] y,
                        input logic v);
        exp_t e;
        a = x;
        b = y;
        in_valid = v;
        e.p = ref_mul(x, y);
        e.v = v;
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check({e.tag, "_p"}, p, e.p);
        check({e.tag, "_v"}, {127'b0, out_valid}, {127'b0, e.v});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        logic [7:0]  pat;

        // Reset held with live operands present
        rst_n = 1'b0;
        a = 64'd5;
        b = 64'd7;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_hold_p", p, 128'd0);
            check("rst_hold_v", {127'b0, out_valid}, 128'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        flush_model();
        step("rst_5x7_a", 64'd5, 64'd7, 1'b1);
        step("rst_5x7_b", 64'd5, 64'd7, 1'b1);
        check("rst_35_literal", p, 128'd35);
        check("rst_35_valid", {127'b0, out_valid}, 128'd1);

        // Identities and corners
        step("zero", 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check("zero_literal", p, 128'd35);
        step("one", 64'd1, 64'hDEAD_BEEF_CAFE_BABE, 1'b1);
        check("zero_literal_out", p, 128'd0);
        step("pow63", 64'h8000_0000_0000_0000, 64'd2, 1'b1);
        check("one_literal", p, 128'h0000_0000_0000_0000_DEAD_BEEF_CAFE_BABE);
        step("max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        check("pow63_literal", p, 128'h0000_0000_0000_0001_0000_0000_0000_0000);
        step("rep", 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 1'b1);
        check("max_literal", p, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        step("swap_one", 64'h0123_4567_89AB_CDEF, 64'd1, 1'b1);
        check("rep_literal", p, 128'h0000_0000_0000_0001_0000_0002_0000_0001);

        // Replicated 32-bit patterns
        for (int i = 0; i < 500; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            step("rand_rep", {r1, r1}, {r2, r2}, 1'($urandom_range(0, 1)));
        end

        // Valid pattern 1,0,1,1,0,1,1,1 with back-to-back operands, then drain
        pat = 8'b1110_1101;
        for (int i = 0; i < 8; i++) begin
            step("pipe", {$urandom, $urandom}, {$urandom, $urandom}, pat[i]);
        end
        step("drain", 64'd0, 64'd0, 1'b0);
        step("drain", 64'd0, 64'd0, 1'b0);

        // Asynchronous reset between edges with two results in flight
        step("inflight_a", {$urandom, 32'h1}, {$urandom, 32'h3}, 1'b1);
        step("inflight_b", {$urandom, 32'h5}, {$urandom, 32'h7}, 1'b1);
        a = 64'hFFFF_FFFF_FFFF_FFFF;
        b = 64'hFFFF_FFFF_FFFF_FFFF;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_p_now", p, 128'd0);
        check("midrst_v_now", {127'b0, out_valid}, 128'd0);
        @(posedge clk);
        #1;
        check("midrst_p_hold", p, 128'd0);
        check("midrst_v_hold", {127'b0, out_valid}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        flush_model();
        for (int i = 0; i < 6; i++) begin
            step("post_rst", {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
